// File: rtl/uart_alu_interface_if.sv
`default_nettype none
// ============================================================================
// uart_alu_interface_if : UART RX/TX and ALU signal bundle for the frame controller
// Rev 1.0
// ============================================================================
interface uart_alu_interface_if #(
   parameter int N = 8
);
   logic [7:0]   i_rx_data;
   logic         i_rx_done;
   logic         i_tx_done;
   logic         o_tx_start;
   logic [7:0]   o_tx_data;
   logic [N-1:0] i_alu_result;
   logic         i_alu_zero;
   logic         i_alu_overflow;
   logic         i_alu_carry;
   logic [N-1:0] o_datoA;
   logic [N-1:0] o_datoB;
   logic [5:0]   o_operacion;
   logic         o_busy;
   logic         o_err;
   logic         o_rx_drop;

   modport slave (
      input  i_rx_data, i_rx_done, i_tx_done,
      input  i_alu_result, i_alu_zero, i_alu_overflow, i_alu_carry,
      output o_tx_start, o_tx_data, o_datoA, o_datoB, o_operacion,
      output o_busy, o_err, o_rx_drop
   );

   modport master (
      output i_rx_data, i_rx_done, i_tx_done,
      output i_alu_result, i_alu_zero, i_alu_overflow, i_alu_carry,
      input  o_tx_start, o_tx_data, o_datoA, o_datoB, o_operacion,
      input  o_busy, o_err, o_rx_drop
   );
endinterface
`default_nettype wire

// File: rtl/uart_alu_interface.sv
`default_nettype none
// ============================================================================
// uart_alu_interface : collects A/B/opcode bytes, runs the ALU, returns result+flags
// Rev 1.0
// ============================================================================
module uart_alu_interface #(
   parameter int N           = 8,
   parameter int TIMEOUT_CYC = 100000
) (
   input wire                  i_clk,
   input wire                  i_rst_n,
   uart_alu_interface_if.slave bus
);

   localparam int c_TO_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

   typedef enum logic [2:0] {
      S_WAIT_A   = 3'd0,
      S_WAIT_B   = 3'd1,
      S_WAIT_OP  = 3'd2,
      S_EXEC     = 3'd3,
      S_SEND_RES = 3'd4,
      S_WAIT_TX1 = 3'd5,
      S_SEND_FLG = 3'd6,
      S_WAIT_TX2 = 3'd7
   } state_t;

   state_t            r_state;
   logic [N-1:0]      r_datoA;
   logic [N-1:0]      r_datoB;
   logic [5:0]        r_operacion;
   logic [7:0]        r_tx_data;
   logic [7:0]        r_flag;
   logic              r_tx_start;
   logic              r_busy;
   logic              r_err;
   logic              r_rx_drop;
   logic [c_TO_W-1:0] r_to_cnt;

   logic              w_op_valid;
   logic              w_in_rx_wait;
   logic              w_to_expire;
   logic              w_to_run;
   logic [7:0]        w_res_ext;

   always_comb begin
      w_op_valid = 1'b0;
      case (bus.i_rx_data)
         8'h20, 8'h22, 8'h24, 8'h25,
         8'h26, 8'h27, 8'h02, 8'h03: w_op_valid = 1'b1;
         default:                    w_op_valid = 1'b0;
      endcase
   end

   // An arriving byte always beats an expiring timeout in the same cycle
   assign w_in_rx_wait = (r_state == S_WAIT_B) || (r_state == S_WAIT_OP);
   assign w_to_expire  = (TIMEOUT_CYC != 0) && w_in_rx_wait && !bus.i_rx_done
                         && (r_to_cnt == c_TO_LAST);
   assign w_to_run     = (TIMEOUT_CYC != 0) && w_in_rx_wait && !bus.i_rx_done
                         && !w_to_expire;
   assign w_res_ext    = 8'(bus.i_alu_result);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_WAIT_A;
         r_datoA     <= '0;
         r_datoB     <= '0;
         r_operacion <= '0;
         r_tx_data   <= '0;
         r_flag      <= '0;
         r_tx_start  <= 1'b0;
         r_busy      <= 1'b0;
         r_err       <= 1'b0;
         r_rx_drop   <= 1'b0;
         r_to_cnt    <= '0;
      end else begin
         r_tx_start <= 1'b0;
         r_err      <= 1'b0;
         r_rx_drop  <= bus.i_rx_done && r_busy;
         r_to_cnt   <= w_to_run ? r_to_cnt + 1'b1 : '0;

         case (r_state)
            S_WAIT_A: begin
               if (bus.i_rx_done) begin
                  r_datoA <= bus.i_rx_data[N-1:0];
                  r_state <= S_WAIT_B;
               end
            end
            S_WAIT_B: begin
               if (bus.i_rx_done) begin
                  r_datoB <= bus.i_rx_data[N-1:0];
                  r_state <= S_WAIT_OP;
               end else if (w_to_expire) begin
                  r_err   <= 1'b1;
                  r_state <= S_WAIT_A;
               end
            end
            S_WAIT_OP: begin
               if (bus.i_rx_done) begin
                  if (w_op_valid) begin
                     r_operacion <= bus.i_rx_data[5:0];
                     r_busy      <= 1'b1;
                     r_state     <= S_EXEC;
                  end else begin
                     r_err   <= 1'b1;
                     r_state <= S_WAIT_A;
                  end
               end else if (w_to_expire) begin
                  r_err   <= 1'b1;
                  r_state <= S_WAIT_A;
               end
            end
            S_EXEC: begin
               r_tx_data  <= w_res_ext;
               r_flag     <= {5'b0, bus.i_alu_carry, bus.i_alu_overflow, bus.i_alu_zero};
               r_tx_start <= 1'b1;
               r_state    <= S_SEND_RES;
            end
            S_SEND_RES: r_state <= S_WAIT_TX1;
            S_WAIT_TX1: begin
               if (bus.i_tx_done) begin
                  r_tx_data  <= r_flag;
                  r_tx_start <= 1'b1;
                  r_state    <= S_SEND_FLG;
               end
            end
            S_SEND_FLG: r_state <= S_WAIT_TX2;
            S_WAIT_TX2: begin
               if (bus.i_tx_done) begin
                  r_busy  <= 1'b0;
                  r_state <= S_WAIT_A;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_WAIT_A;
            end
         endcase
      end
   end

   assign bus.o_tx_start  = r_tx_start;
   assign bus.o_tx_data   = r_tx_data;
   assign bus.o_datoA     = r_datoA;
   assign bus.o_datoB     = r_datoB;
   assign bus.o_operacion = r_operacion;
   assign bus.o_busy      = r_busy;
   assign bus.o_err       = r_err;
   assign bus.o_rx_drop   = r_rx_drop;

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_interface.sv
`default_nettype none
// ============================================================================
// tb_uart_alu_interface : directed frames with a reference ALU and a tx-byte scoreboard
// Rev 1.0
// ============================================================================
module tb_uart_alu_interface;

   localparam int N  = 8;
   localparam int TO = 50;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_alu_interface_if #(.N(N)) ifc ();

   uart_alu_interface #(.N(N), .TIMEOUT_CYC(TO)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (ifc.slave)
   );

   int         n_tests = 0;
   int         n_fail  = 0;
   int         err_cnt = 0;
   int         drop_cnt = 0;
   logic [7:0] exp_q[$];
   logic       holding = 1'b0;
   logic [7:0] held    = 8'h00;

   // Reference ALU driven from the registered operands
   logic [7:0] alu_a, alu_b, alu_r;
   logic       alu_c, alu_v;
   always_comb begin
      alu_a = ifc.o_datoA;
      alu_b = ifc.o_datoB;
      alu_r = 8'h00;
      alu_c = 1'b0;
      alu_v = 1'b0;
      case (ifc.o_operacion)
         6'h20: begin
            {alu_c, alu_r} = {1'b0, alu_a} + {1'b0, alu_b};
            alu_v = (alu_a[7] == alu_b[7]) && (alu_r[7] != alu_a[7]);
         end
         6'h22: begin
            {alu_c, alu_r} = {1'b0, alu_a} - {1'b0, alu_b};
            alu_v = (alu_a[7] != alu_b[7]) && (alu_r[7] != alu_a[7]);
         end
         6'h24:   alu_r = alu_a & alu_b;
         6'h25:   alu_r = alu_a | alu_b;
         6'h26:   alu_r = alu_a ^ alu_b;
         6'h27:   alu_r = ~(alu_a | alu_b);
         6'h02:   alu_r = alu_a >> alu_b;
         6'h03:   alu_r = $signed(alu_a) >>> alu_b;
         default: alu_r = 8'h00;
      endcase
      ifc.i_alu_result   = alu_r;
      ifc.i_alu_zero     = (alu_r == 8'h00);
      ifc.i_alu_carry    = alu_c;
      ifc.i_alu_overflow = alu_v;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor: every tx_start consumes one expected byte, data must hold until tx_done
   always @(negedge clk) begin
      if (ifc.o_err)     err_cnt++;
      if (ifc.o_rx_drop) drop_cnt++;
      if (!rst_n) begin
         holding = 1'b0;
      end else if (ifc.o_tx_start) begin
         if (exp_q.size() == 0) chk("tx_unexpected_qsize", exp_q.size(), 1);
         else                   chk("tx_data", {24'h0, ifc.o_tx_data}, {24'h0, exp_q.pop_front()});
         chk("busy_at_tx", ifc.o_busy, 1);
         holding = 1'b1;
         held    = ifc.o_tx_data;
      end else if (holding) begin
         chk("tx_hold", {24'h0, ifc.o_tx_data}, {24'h0, held});
         if (ifc.i_tx_done) holding = 1'b0;
      end
   end

   // UART TX model: acknowledges each byte three cycles after the request
   initial begin
      ifc.i_tx_done = 1'b0;
      forever begin
         @(negedge clk);
         if (ifc.o_tx_start && rst_n) begin
            repeat (3) @(posedge clk);
            #1 ifc.i_tx_done = 1'b1;
            @(posedge clk);
            #1 ifc.i_tx_done = 1'b0;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      ifc.i_rx_data = b;
      ifc.i_rx_done = 1'b1;
      @(posedge clk); #1;
      ifc.i_rx_done = 1'b0;
   endtask

   task automatic wait_tx_start();
      int k = 0;
      @(negedge clk);
      while (!ifc.o_tx_start && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("tx_start_seen", ifc.o_tx_start, 1);
   endtask

   task automatic wait_drain(input string tag);
      int k = 0;
      @(negedge clk);
      while ((ifc.o_busy || exp_q.size() != 0) && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk(tag, exp_q.size(), 0);
      chk("idle_after_frame", ifc.o_busy, 0);
   endtask

   task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                            input logic [7:0] res, input logic [7:0] flg);
      exp_q.push_back(res);
      exp_q.push_back(flg);
      send_byte(a);
      send_byte(b);
      send_byte(op);
      wait_drain("frame_drain");
   endtask

   initial begin
      int e0;
      int d0;
      int first;
      ifc.i_rx_data = 8'h00;
      ifc.i_rx_done = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_data", {8'h0, ifc.o_datoA, ifc.o_datoB, ifc.o_tx_data}, 32'h0);
      chk("rst_ctrl", {22'h0, ifc.o_operacion, ifc.o_tx_start, ifc.o_busy, ifc.o_err, ifc.o_rx_drop}, 32'h0);
      @(posedge clk); #1 rst_n = 1'b1;

      // ADD 5+3 with latency and operand checks
      exp_q.push_back(8'h08);
      exp_q.push_back(8'h00);
      send_byte(8'h05);
      send_byte(8'h03);
      send_byte(8'h20);
      @(negedge clk);
      chk("busy_exec", ifc.o_busy, 1);
      chk("no_start_exec", ifc.o_tx_start, 0);
      chk("operands", {8'h0, ifc.o_datoA, ifc.o_datoB, 2'b00, ifc.o_operacion}, 32'h0005_0320);
      @(negedge clk);
      chk("latency_tx_start", ifc.o_tx_start, 1);
      wait_drain("frame1_drain");

      run_frame(8'h7F, 8'h01, 8'h20, 8'h80, 8'h02);
      run_frame(8'hFF, 8'h01, 8'h20, 8'h00, 8'h05);
      run_frame(8'hB4, 8'h02, 8'h03, 8'hED, 8'h00);

      // Invalid opcode
      e0 = err_cnt;
      send_byte(8'h05);
      send_byte(8'h03);
      send_byte(8'h21);
      @(negedge clk);
      chk("err_invalid", ifc.o_err, 1);
      @(negedge clk);
      chk("err_single", ifc.o_err, 0);
      repeat (5) @(negedge clk);
      chk("err_count_invalid", err_cnt - e0, 1);
      chk("op_unchanged", ifc.o_operacion, 6'h03);
      chk("busy_invalid", ifc.o_busy, 0);
      run_frame(8'h0A, 8'h03, 8'h22, 8'h07, 8'h00);

      // Timeout after operand A
      e0 = err_cnt;
      first = 0;
      send_byte(8'h11);
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (ifc.o_err && first == 0) first = i;
      end
      chk("timeout_cycle", first, 51);
      chk("err_count_timeout", err_cnt - e0, 1);
      chk("partial_A_kept", ifc.o_datoA, 8'h11);
      run_frame(8'h01, 8'h02, 8'h25, 8'h03, 8'h00);

      // Byte arriving on the last allowed cycle wins
      e0 = err_cnt;
      send_byte(8'h11);
      repeat (48) @(posedge clk);
      send_byte(8'h13);
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h00);
      send_byte(8'h24);
      wait_drain("edge_drain");
      chk("edge_no_err", err_cnt - e0, 0);
      chk("edge_B", ifc.o_datoB, 8'h13);

      // Byte received while waiting for tx_done is dropped
      d0 = drop_cnt;
      exp_q.push_back(8'h07);
      exp_q.push_back(8'h00);
      send_byte(8'h03);
      send_byte(8'h04);
      send_byte(8'h20);
      wait_tx_start();
      @(posedge clk); #1;
      ifc.i_rx_data = 8'h99;
      ifc.i_rx_done = 1'b1;
      @(posedge clk); #1;
      ifc.i_rx_done = 1'b0;
      wait_drain("drop_drain");
      chk("drop_count", drop_cnt - d0, 1);
      run_frame(8'h06, 8'h01, 8'h22, 8'h05, 8'h00);
      chk("aligned_A", ifc.o_datoA, 8'h06);

      // Asynchronous reset while waiting for the first tx_done
      exp_q.push_back(8'h0A);
      exp_q.push_back(8'h00);
      send_byte(8'h09);
      send_byte(8'h01);
      send_byte(8'h20);
      wait_tx_start();
      @(posedge clk); #1;
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_data", {8'h0, ifc.o_datoA, ifc.o_datoB, ifc.o_tx_data}, 32'h0);
      chk("async_rst_ctrl", {22'h0, ifc.o_operacion, ifc.o_tx_start, ifc.o_busy, ifc.o_err, ifc.o_rx_drop}, 32'h0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("busy_after_rst", ifc.o_busy, 0);
      run_frame(8'h02, 8'h02, 8'h26, 8'h00, 8'h01);

      chk("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
